// File: rtl/sprite_line_fetch_if.sv
// Signal bundle between the XGA timing/register side and the sprite line fetcher.
// The slave modport is the fetcher's view; master is the driving side.
interface sprite_line_fetch_if;
   logic        en;
   logic [10:0] h_cnt;
   logic [9:0]  v_cnt;
   logic [7:0]  spr0_x;
   logic [7:0]  spr0_y;
   logic [63:0] spr0_bmp;
   logic [7:0]  spr1_x;
   logic [7:0]  spr1_y;
   logic [63:0] spr1_bmp;
   logic        coll_clr;
   logic        pixel_on;
   logic [1:0]  spr_hit;
   logic        collision;
   logic        fetch_busy;

   modport master (
      output en, h_cnt, v_cnt, spr0_x, spr0_y, spr0_bmp, spr1_x, spr1_y, spr1_bmp, coll_clr,
      input  pixel_on, spr_hit, collision, fetch_busy
   );

   modport slave (
      input  en, h_cnt, v_cnt, spr0_x, spr0_y, spr0_bmp, spr1_x, spr1_y, spr1_bmp, coll_clr,
      output pixel_on, spr_hit, collision, fetch_busy
   );
endinterface

// File: rtl/sprite_line_fetch.sv
// Two-sprite 8x8 scanline fetcher: loads next-line rows into shadow registers during
// horizontal blanking, swaps them in at line end, and shifts out per-pixel hits.
module sprite_line_fetch #(
   parameter int unsigned H_ACTIVE   = 1024,
   parameter int unsigned H_TOTAL    = 1344,
   parameter int unsigned V_ACTIVE   = 768,
   parameter int unsigned V_TOTAL    = 806,
   parameter int unsigned SCALE_LOG2 = 2
) (
   input logic                clk,
   input logic                rst_n,
   sprite_line_fetch_if.slave bus
);

   localparam logic [10:0] HActive = 11'(H_ACTIVE);
   localparam logic [10:0] HLast   = 11'(H_TOTAL - 1);
   localparam logic [9:0]  VActive = 10'(V_ACTIVE);
   localparam logic [9:0]  VLast   = 10'(V_TOTAL - 1);

   typedef enum logic [1:0] {StIdle, StFetch0, StFetch1, StDone} state_e;

   state_e     state_q, state_d;
   logic [7:0] shadow_row0_q, shadow_row0_d, shadow_row1_q, shadow_row1_d;
   logic [7:0] shadow_x0_q, shadow_x0_d, shadow_x1_q, shadow_x1_d;
   logic [7:0] active_row0_q, active_row0_d, active_row1_q, active_row1_d;
   logic [7:0] active_x0_q, active_x0_d, active_x1_q, active_x1_d;
   logic [1:0] spr_hit_q;
   logic       collision_q, collision_d;

   logic [9:0] tv;
   logic [7:0] tly;
   logic [7:0] lx;
   logic       tline_act;
   logic       video_active;
   logic       pix0, pix1;

   // 9-bit compares so a sprite near 255 clips instead of wrapping to 0.
   function automatic logic in_window(input logic [7:0] pos, input logic [7:0] base);
      return ({1'b0, pos} >= {1'b0, base}) && ({1'b0, pos} < ({1'b0, base} + 9'd8));
   endfunction

   function automatic logic [7:0] bmp_row(input logic [63:0] bmp, input logic [2:0] r);
      return bmp[{r, 3'b000} +: 8];
   endfunction

   function automatic logic pix_lit(input logic [7:0] pos, input logic [7:0] base,
                                    input logic [7:0] row);
      logic [2:0] col;
      col = 3'(pos - base);
      return in_window(pos, base) && row[col];
   endfunction

   always_comb begin
      tv           = (bus.v_cnt == VLast) ? 10'd0 : bus.v_cnt + 10'd1;
      tly          = 8'(tv >> SCALE_LOG2);
      tline_act    = (tv < VActive);
      lx           = 8'(bus.h_cnt >> SCALE_LOG2);
      video_active = (bus.h_cnt < HActive) && (bus.v_cnt < VActive);
      pix0         = video_active && pix_lit(lx, active_x0_q, active_row0_q);
      pix1         = video_active && pix_lit(lx, active_x1_q, active_row1_q);
   end

   always_comb begin
      state_d       = state_q;
      shadow_row0_d = shadow_row0_q;
      shadow_row1_d = shadow_row1_q;
      shadow_x0_d   = shadow_x0_q;
      shadow_x1_d   = shadow_x1_q;
      active_row0_d = active_row0_q;
      active_row1_d = active_row1_q;
      active_x0_d   = active_x0_q;
      active_x1_d   = active_x1_q;

      case (state_q)
         StIdle: begin
            if (bus.h_cnt == HActive) state_d = StFetch0;
         end
         StFetch0: begin
            state_d = StFetch1;
            if (tline_act && in_window(tly, bus.spr0_y)) begin
               shadow_row0_d = bmp_row(bus.spr0_bmp, 3'(tly - bus.spr0_y));
               shadow_x0_d   = bus.spr0_x;
            end else begin
               shadow_row0_d = 8'd0;
            end
         end
         StFetch1: begin
            state_d = StDone;
            if (tline_act && in_window(tly, bus.spr1_y)) begin
               shadow_row1_d = bmp_row(bus.spr1_bmp, 3'(tly - bus.spr1_y));
               shadow_x1_d   = bus.spr1_x;
            end else begin
               shadow_row1_d = 8'd0;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Both sprites switch together so a line never mixes old and new data.
      if (bus.h_cnt == HLast) begin
         active_row0_d = shadow_row0_q;
         active_row1_d = shadow_row1_q;
         active_x0_d   = shadow_x0_q;
         active_x1_d   = shadow_x1_q;
      end
   end

   // Clear is honoured even while stalled; a coincident set takes precedence.
   always_comb begin
      collision_d = collision_q;
      if (bus.en && pix0 && pix1) begin
         collision_d = 1'b1;
      end else if (bus.coll_clr) begin
         collision_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         shadow_row0_q <= 8'd0;
         shadow_row1_q <= 8'd0;
         shadow_x0_q   <= 8'd0;
         shadow_x1_q   <= 8'd0;
         active_row0_q <= 8'd0;
         active_row1_q <= 8'd0;
         active_x0_q   <= 8'd0;
         active_x1_q   <= 8'd0;
         spr_hit_q     <= 2'd0;
         collision_q   <= 1'b0;
      end else begin
         if (bus.en) begin
            state_q       <= state_d;
            shadow_row0_q <= shadow_row0_d;
            shadow_row1_q <= shadow_row1_d;
            shadow_x0_q   <= shadow_x0_d;
            shadow_x1_q   <= shadow_x1_d;
            active_row0_q <= active_row0_d;
            active_row1_q <= active_row1_d;
            active_x0_q   <= active_x0_d;
            active_x1_q   <= active_x1_d;
            spr_hit_q     <= {pix1, pix0};
         end
         collision_q <= collision_d;
      end
   end

   assign bus.spr_hit    = spr_hit_q;
   assign bus.pixel_on   = |spr_hit_q;
   assign bus.collision  = collision_q;
   assign bus.fetch_busy = (state_q != StIdle);

endmodule
